// File: rtl/regfile_2r1w_pkg.sv
// Shared constants and sizing helper for the 2-read/1-write register file.
package regfile_2r1w_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Number of registers addressable with an aw-bit address.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Address to one-hot strobe decoder; all strobes low when en is low.
module onehot_dec
  import regfile_2r1w_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                          en,
  input  logic [ADDR_W-1:0]             addr,
  output logic [depth_of(ADDR_W)-1:0]   strobe
);

  // Exactly one strobe set when enabled, none otherwise.
  always_comb begin
    strobe = '0;
    if (en) begin
      strobe[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Flop-based register file: one write port, two registered read ports with
// write-first bypass, synchronous clear and optional hardwired-zero register 0.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid1,
  output logic              rvalid2
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  wr_strobe;
  logic [DATA_W-1:0] mem1_p0;
  logic [DATA_W-1:0] mem2_p0;
  logic [DATA_W-1:0] rd1_p0;
  logic [DATA_W-1:0] rd2_p0;
  logic [DATA_W-1:0] rdata1_p1;
  logic [DATA_W-1:0] rdata2_p1;
  logic              vld1_p1;
  logic              vld2_p1;

  // Priority: hardwired zero, then same-edge clear, then write-first
  // bypass, then the stored contents.
  function automatic logic [DATA_W-1:0] read_value(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              clr_i,
    input logic              we_i,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if ((ZERO_REG != 0) && (ra == '0)) begin
      return '0;
    end else if (clr_i) begin
      return '0;
    end else if (we_i && (wa == ra)) begin
      return wd;
    end else begin
      return stored;
    end
  endfunction

  onehot_dec #(
    .ADDR_W (ADDR_W)
  ) u_wdec (
    .en     (we),
    .addr   (waddr),
    .strobe (wr_strobe)
  );

  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    if ((ZERO_REG != 0) && (k == 0)) begin : g_zero
      // Register 0 is a constant zero; writes to it are discarded.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[k] <= '0;
        end else begin
          regs_q[k] <= '0;
        end
      end
    end else begin : g_store
      // Clear wins over a write on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_q[k] <= '0;
        end else if (clr) begin
          regs_q[k] <= '0;
        end else if (wr_strobe[k]) begin
          regs_q[k] <= wdata;
        end
      end
    end
  end

  assign mem1_p0 = regs_q[raddr1];
  assign mem2_p0 = regs_q[raddr2];

  // Stage p0: resolve the value each port would see on this edge.
  always_comb begin
    rd1_p0 = read_value(raddr1, mem1_p0, clr, we, waddr, wdata);
    rd2_p0 = read_value(raddr2, mem2_p0, clr, we, waddr, wdata);
  end

  // Stage p0 -> p1: capture read data on request, hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1_p1 <= '0;
      rdata2_p1 <= '0;
      vld1_p1   <= 1'b0;
      vld2_p1   <= 1'b0;
    end else begin
      vld1_p1 <= re1;
      vld2_p1 <= re2;
      if (re1) begin
        rdata1_p1 <= rd1_p0;
      end
      if (re2) begin
        rdata2_p1 <= rd2_p0;
      end
    end
  end

  assign rdata1  = rdata1_p1;
  assign rdata2  = rdata2_p1;
  assign rvalid1 = vld1_p1;
  assign rvalid2 = vld2_p1;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: one instance with a hardwired-zero
// register 0 and one with ordinary register 0, sharing all inputs.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        clr = 1'b0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;

  logic [31:0] rdata1, rdata2, z_rdata1, z_rdata2;
  logic        rvalid1, rvalid2, z_rvalid1, z_rvalid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .clr(clr), .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rvalid1(rvalid1), .rvalid2(rvalid2)
  );

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .clr(clr), .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(z_rdata1), .rdata2(z_rdata2), .rvalid1(z_rvalid1), .rvalid2(z_rvalid2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted: everything reads zero without a clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_rvalid1", {31'b0, rvalid1}, 32'h0);
    check("rst_rvalid2", {31'b0, rvalid2}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Write reg5, then read it on port 1 (first edge after reset is normal).
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    tick();
    check("rd5_rdata1", rdata1, 32'hDEADBEEF);
    check("rd5_rvalid1", {31'b0, rvalid1}, 32'h1);
    check("rd5_rvalid2", {31'b0, rvalid2}, 32'h0);
    re1 = 1'b0;

    // Register 0: discarded write vs ordinary storage.
    we = 1'b1; waddr = 5'd0; wdata = 32'h00001234;
    tick();
    we = 1'b0; re2 = 1'b1; raddr2 = 5'd0;
    tick();
    check("zero_rdata2", rdata2, 32'h0);
    check("nz_rdata2", z_rdata2, 32'h00001234);
    check("zero_rvalid2", {31'b0, rvalid2}, 32'h1);
    re2 = 1'b0;

    // Write-first bypass seen identically on both ports.
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    tick();
    check("byp_rdata1", rdata1, 32'hA5A5A5A5);
    check("byp_rdata2", rdata2, 32'hA5A5A5A5);
    we = 1'b0;
    tick();
    check("byp_stored", rdata1, 32'hA5A5A5A5);
    re1 = 1'b0; re2 = 1'b0;

    // Fill every register with its own index.
    for (int k = 0; k < 32; k++) begin
      we = 1'b1; waddr = 5'(k); wdata = 32'(k);
      tick();
    end
    we = 1'b0;
    re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd0;
    tick();
    check("fill_r31", rdata1, 32'd31);
    check("fill_r0_zero", rdata2, 32'd0);
    check("fill_r0_nz", z_rdata2, 32'd0);
    raddr1 = 5'd3; raddr2 = 5'd18;
    tick();
    check("fill_r3", rdata1, 32'd3);
    check("fill_r18", rdata2, 32'd18);
    re2 = 1'b0;

    // Clear beats a same-edge write and a same-edge read returns zero.
    clr = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
    re1 = 1'b1; raddr1 = 5'd3;
    tick();
    check("clr_rdata1", rdata1, 32'h0);
    clr = 1'b0; we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      re1 = 1'b1; raddr1 = 5'(k); re2 = 1'b1; raddr2 = 5'(31 - k);
      tick();
      check("clr_all_p1", rdata1, 32'h0);
      check("clr_all_nz", z_rdata2, 32'h0);
    end
    re1 = 1'b0; re2 = 1'b0;

    // Read 0x55, then idle port 1 for three edges: data held, valid low.
    we = 1'b1; waddr = 5'd10; wdata = 32'h00000055;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd10;
    tick();
    check("hold_first", rdata1, 32'h00000055);
    re1 = 1'b0; raddr1 = 5'd5;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_rdata1", rdata1, 32'h00000055);
      check("hold_rvalid1", {31'b0, rvalid1}, 32'h0);
    end

    // Reset in the middle of a write/read cycle.
    re1 = 1'b1; raddr1 = 5'd10;
    tick();
    check("prerst_rvalid1", {31'b0, rvalid1}, 32'h1);
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000CAFE;
    re1 = 1'b1; raddr1 = 5'd12;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rdata1", rdata1, 32'h0);
    check("midrst_rvalid1", {31'b0, rvalid1}, 32'h0);
    check("midrst_nz_rdata2", z_rdata2, 32'h0);
    tick();
    check("midrst_hold_rdata1", rdata1, 32'h0);
    we = 1'b0; re1 = 1'b0;
    rst_n = 1'b1;
    re1 = 1'b1; raddr1 = 5'd12; re2 = 1'b1; raddr2 = 5'd10;
    tick();
    check("postrst_r12", rdata1, 32'h0);
    check("postrst_r10", rdata2, 32'h0);
    check("postrst_rvalid1", {31'b0, rvalid1}, 32'h1);
    raddr2 = 5'd0;
    tick();
    check("postrst_nz_r0", z_rdata2, 32'h0);
    re1 = 1'b0; re2 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter DATA_W, default 32, meaning width of each register in bits.
REQ-002 Parameter ADDR_W, default 5, meaning address width; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, meaning 1 = register 0 is hardwired to zero and ignores writes; 0 = register 0 is ordinary storage.
REQ-004 Clocking SHALL be one clock with an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 we  input  1  write enable for the single write port.
REQ-008 waddr  input  ADDR_W  write address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 clr  input  1  synchronous clear of all registers.
REQ-011 re1 / re2  input  1  read request, ports 1 and 2.
REQ-012 raddr1 / raddr2  input  ADDR_W  read address, ports 1 and 2.
REQ-013 rdata1 / rdata2  output  DATA_W  registered read data, ports 1 and 2.
REQ-014 rvalid1 / rvalid2  output  1  rdataN was updated by a read on the previous edge.

Function
REQ-015 Write decode SHALL be one-hot: write strobe k is asserted iff we=1 and waddr=k; at most one register is written per edge.
REQ-016 On a rising edge with we=1, clr=0, register[waddr] SHALL take wdata, except when ZERO_REG=1 and waddr=0, where the write is discarded.
REQ-017 On a rising edge with clr=1, every register SHALL become 0, regardless of we.
REQ-018 Read latency SHALL be exactly one cycle: on the edge where reN=1, rdataN captures the read value and rvalidN becomes 1.
REQ-019 On an edge where reN=0, rdataN SHALL hold its previous value and rvalidN SHALL become 0.
REQ-020 Read value SHALL be 0 when ZERO_REG=1 and raddrN=0.
REQ-021 The read value SHALL otherwise be 0 when clr=1 on the same edge.
REQ-022 The read value SHALL otherwise be wdata when we=1 and waddr=raddrN on the same edge (write-first bypass).
REQ-023 In all other cases the read value SHALL be register[raddrN] as stored before the edge.
REQ-024 Both ports SHALL be independent; identical raddr1=raddr2 SHALL return identical data, including the bypass case.
REQ-025 Address wrap SHALL NOT occur; every ADDR_W-bit value is a valid register.

Reset
REQ-026 While rst_n=0, all registers, rdata1, and rdata2 SHALL be 0, and rvalid1 and rvalid2 SHALL be 0, asynchronously.
REQ-027 A reset asserted mid-operation SHALL discard any same-cycle write or read.
REQ-028 The first edge after rst_n deasserts SHALL behave as a normal edge.

Structure
REQ-029 A shared package SHALL hold the default DATA_W/ADDR_W constants and a DEPTH helper function.
REQ-030 One sub-module onehot_dec SHALL be used, parametrised by ADDR_W, with inputs addr and en and output DEPTH-bit one-hot strobes (all-zero when en=0).
REQ-031 Storage SHALL be flops, not inferred RAM, so that clear and reset act on all registers in one cycle.

Verification
REQ-032 Reset, write reg5=0xDEADBEEF, then re1 raddr1=5 -> one cycle later rdata1=0xDEADBEEF, rvalid1=1.
REQ-033 ZERO_REG=1: write reg0=0x1234, read port2 addr0 -> rdata2=0. ZERO_REG=0: same sequence -> rdata2=0x1234.
REQ-034 Same edge: we=1 waddr=7 wdata=0xA5A5A5A5, re1 raddr1=7, re2 raddr2=7 -> both rdata=0xA5A5A5A5 next cycle.
REQ-035 Fill all 32 registers with the value k. Assert clr with we=1 waddr=3 and re1 raddr1=3 -> rdata1=0; then all registers read 0.
REQ-036 Hold re1=0 for 3 cycles after a read of 0x55 -> rdata1 stays 0x55 and rvalid1=0.
REQ-037 Assert rst_n low mid-write -> registers, rdata, and rvalid are 0 immediately, and the write is lost after release.
